// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART FSM states and line constants shared by the transmitter and receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

  localparam logic LSB_FIRST  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous FIFO, read data registered one cycle after rd_en
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ok, rd_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    wr_ok     = wr_en && !full;
    rd_ok     = rd_en && !empty;
    wr_ptr_d  = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_data_d = rd_ok ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - FIFO-fed UART transmit framer
// Parity ports and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 32,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data,
  input  logic              dataWen,
  input  logic [DIV_W-1:0]  baudDiv,
  input  logic              stop2,
`ifdef UART_TX_PARITY_EN
  input  logic              parityEn,
  input  logic              parityOdd,
`endif
  output logic              fifoFull,
  output logic              fifoEmpty,
  output logic              busy,
  output logic              txDone,
  output logic              sOut
);

  localparam int BW = $clog2(DWIDTH + 1);

  logic              fifo_rd;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;

  fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (dataWen),
    .wr_data (data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  uart_state_e       state_q, state_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_hi_q, stop_hi_d;
  logic              sout_q, sout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
`endif

  logic              tick;
  logic              next_bit;
  logic [DWIDTH-1:0] shift_next;

  always_comb begin
    tick       = (cnt_q == div_q);
    next_bit   = LSB_FIRST ? shift_q[0] : shift_q[DWIDTH-1];
    shift_next = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

    fifo_rd    = 1'b0;
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bit_d      = bit_q;
    stop2_d    = stop2_q;
    stop_hi_d  = stop_hi_q;
    sout_d     = sout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_d      = par_q;
`endif

    if (state_q == ST_IDLE || state_q == ST_LOAD || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // sout_d is set one state ahead so the registered line changes on entry.
    case (state_q)
      ST_IDLE: begin
        sout_d = IDLE_LEVEL;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d   = fifo_rdata;
        div_d     = baudDiv;
        stop2_d   = stop2;
        stop_hi_d = 1'b0;
        bit_d     = '0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = parityEn;
        par_d     = (^fifo_rdata) ^ parityOdd;
`endif
        busy_d    = 1'b1;
        sout_d    = ~IDLE_LEVEL;
        state_d   = ST_START;
      end
      ST_START: begin
        if (tick) begin
          sout_d  = next_bit;
          shift_d = shift_next;
          bit_d   = BW'(1);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == BW'(DWIDTH)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              sout_d  = par_q;
              state_d = ST_PARITY;
            end else begin
              sout_d  = IDLE_LEVEL;
              state_d = ST_STOP;
            end
`else
            sout_d  = IDLE_LEVEL;
            state_d = ST_STOP;
`endif
          end else begin
            sout_d  = next_bit;
            shift_d = shift_next;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          sout_d  = IDLE_LEVEL;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_hi_q) begin
            stop_hi_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        sout_d  = IDLE_LEVEL;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop2_q   <= 1'b0;
      stop_hi_q <= 1'b0;
      sout_q    <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop2_q   <= stop2_d;
      stop_hi_q <= stop_hi_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_q     <= par_d;
`endif
    end
  end

  assign fifoFull  = fifo_full;
  assign fifoEmpty = fifo_empty;
  assign busy      = busy_q;
  assign txDone    = done_q;
  assign sOut      = sout_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = '0;
  logic        dataWen = 1'b0;
  logic [15:0] baudDiv = '0;
  logic        stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic        parityEn = 1'b0;
  logic        parityOdd = 1'b0;
`endif
  logic        fifoFull, fifoEmpty, busy, txDone, sOut;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_framer dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .dataWen   (dataWen),
    .baudDiv   (baudDiv),
    .stop2     (stop2),
`ifdef UART_TX_PARITY_EN
    .parityEn  (parityEn),
    .parityOdd (parityOdd),
`endif
    .fifoFull  (fifoFull),
    .fifoEmpty (fifoEmpty),
    .busy      (busy),
    .txDone    (txDone),
    .sOut      (sOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    data    = d;
    dataWen = 1'b1;
    @(negedge clk);
    dataWen = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (sOut !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, {31'b0, sOut}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (txDone !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'b0, txDone}, 32'd1);
  endtask

  // Samples every clock of one frame; leaves the bench on the txDone sample.
  task automatic check_frame(input string tag, input logic [7:0] d, input int per,
                             input int nstop, input bit has_par, input logic par);
    logic lv [0:15];
    int   nlev, hits, dn, bl;
    wait_start(tag);
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[1 + i] = d[i];
    nlev = 9;
    if (has_par) begin
      lv[nlev] = par;
      nlev++;
    end
    for (int s = 0; s < nstop; s++) begin
      lv[nlev] = 1'b1;
      nlev++;
    end
    dn = 0;
    bl = 0;
    for (int l = 0; l < nlev; l++) begin
      hits = 0;
      for (int c = 0; c < per; c++) begin
        if (sOut === lv[l]) hits++;
        if (txDone === 1'b1) dn++;
        if (busy !== 1'b1) bl++;
        @(negedge clk);
      end
      chk($sformatf("%s_lvl%0d", tag, l), hits, per);
    end
    chk({tag, "_done_early"}, dn, 0);
    chk({tag, "_busy_low"}, bl, 0);
    chk({tag, "_txdone"}, {31'b0, txDone}, 32'd1);
    chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int nlow;

    repeat (2) @(negedge clk);
    chk("rst_sout", {31'b0, sOut}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_txdone", {31'b0, txDone}, 32'd0);
    chk("rst_empty", {31'b0, fifoEmpty}, 32'd1);
    chk("rst_full", {31'b0, fifoFull}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x55, 4-clock bits; mid-frame control changes must not affect it
    baudDiv = 16'd3;
    stop2   = 1'b0;
    push(8'h55);
    wait_start("f55");
    baudDiv = 16'd7;
    stop2   = 1'b1;
    check_frame("f55", 8'h55, 4, 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("f55_pulse_end", {31'b0, txDone}, 32'd0);
    chk("f55_idle", {31'b0, sOut}, 32'd1);

    // two stop bits at a 2-clock bit period
    baudDiv = 16'd1;
    stop2   = 1'b1;
    push(8'hA3);
    check_frame("fa3", 8'hA3, 2, 2, 1'b0, 1'b0);

    // back-to-back frames, one-clock bits
    baudDiv = 16'd0;
    stop2   = 1'b0;
    push(8'h3C);
    push(8'hC3);
    check_frame("b2b1", 8'h3C, 1, 1, 1'b0, 1'b0);
    chk("b2b_gap0", {31'b0, sOut}, 32'd1);
    @(negedge clk);
    chk("b2b_gap1", {31'b0, sOut}, 32'd1);
    @(negedge clk);
    chk("b2b_next_start", {31'b0, sOut}, 32'd0);
    check_frame("b2b2", 8'hC3, 1, 1, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
    parityEn  = 1'b1;
    parityOdd = 1'b0;
    push(8'h07);
    check_frame("par_even", 8'h07, 1, 1, 1'b1, 1'b1);
    parityOdd = 1'b1;
    push(8'h07);
    check_frame("par_odd", 8'h07, 1, 1, 1'b1, 1'b0);
    parityEn  = 1'b0;
    parityOdd = 1'b0;
`endif

    // fill the FIFO while a slow frame occupies the transmitter
    baudDiv = 16'd63;
    push(8'h11);
    wait_start("ff0");
    baudDiv = 16'd0;
    for (int i = 0; i < 33; i++) begin
      data    = 8'(8'h20 + i);
      dataWen = 1'b1;
      @(negedge clk);
      if (i == 30) chk("ff_not_full_31", {31'b0, fifoFull}, 32'd0);
      if (i == 31) chk("ff_full_32", {31'b0, fifoFull}, 32'd1);
    end
    dataWen = 1'b0;
    chk("ff_full_33", {31'b0, fifoFull}, 32'd1);
    chk("ff_busy", {31'b0, busy}, 32'd1);
    wait_done("ff0", 2000);
    for (int k = 0; k < 32; k++) begin
      check_frame($sformatf("ff%0d", k + 1), 8'(8'h20 + k), 1, 1, 1'b0, 1'b0);
    end
    nlow = 0;
    repeat (40) begin
      @(negedge clk);
      if (sOut !== 1'b1) nlow++;
    end
    chk("ff_no_extra_frame", nlow, 0);
    chk("ff_empty_after", {31'b0, fifoEmpty}, 32'd1);
    chk("ff_full_after", {31'b0, fifoFull}, 32'd0);

    // asynchronous reset in the middle of DATA with a word still queued
    baudDiv = 16'd3;
    push(8'hF0);
    push(8'h0F);
    wait_start("rs");
    repeat (5) @(negedge clk);
    chk("rs_pre_sout", {31'b0, sOut}, 32'd0);
    chk("rs_pre_busy", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_sout", {31'b0, sOut}, 32'd1);
    chk("rs_async_busy", {31'b0, busy}, 32'd0);
    chk("rs_async_empty", {31'b0, fifoEmpty}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    nlow = 0;
    repeat (200) begin
      @(negedge clk);
      if (sOut !== 1'b1 || busy !== 1'b0 || txDone !== 1'b0) nlow++;
    end
    chk("rs_no_frames", nlow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DWIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter FDEPTH, default 32: transmit FIFO depth in words, power of two.
REQ-003 Parameter DIV_W, default 16: width of the runtime baud divisor.
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 data  in  DWIDTH  word to enqueue.
REQ-007 dataWen  in  1  enqueue strobe, one word per cycle.
REQ-008 baudDiv  in  DIV_W  bit period is baudDiv+1 clk cycles.
REQ-009 stop2  in  1  0 selects one stop bit, 1 selects two stop bits.
REQ-010 parityEn, parityOdd  in  1 each  parity enable and odd select; present only with UART_TX_PARITY_EN.
REQ-011 fifoFull, fifoEmpty  out  1 each  FIFO status.
REQ-012 busy  out  1  high from frame load until the last stop bit ends.
REQ-013 txDone  out  1  one-cycle pulse at the end of each frame's last stop bit.
REQ-014 sOut  out  1  serial line, idle high.

Function
REQ-015 A write with fifoFull high is dropped, and FIFO contents are unchanged.
REQ-016 FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-017 IDLE: when fifoEmpty is low, the block pulses the FIFO read and goes to LOAD; sOut is 1 and busy is 0.
REQ-018 LOAD (one cycle): the block latches the FIFO output, baudDiv, stop2 and parity controls into frame registers, clears the baud counter, sets busy, and goes to START.
REQ-019 The baud counter runs only outside IDLE and LOAD, and ticks when the count equals the latched divisor, then wraps to 0.
REQ-020 baudDiv=0 gives a one-cycle bit period.
REQ-021 Input changes during a frame take effect only at the next LOAD.
REQ-022 START drives sOut=0 for one bit period; DATA shifts DWIDTH bits LSB-first, one per bit period.
REQ-023 PARITY (only when enabled) drives the XOR of the data bits, inverted when parityOdd is set, for one bit period.
REQ-024 STOP drives sOut=1 for one bit period, or two when stop2 was latched.
REQ-025 At the end of STOP, txDone pulses and the FSM returns to IDLE.
REQ-026 Back-to-back frames: exactly two high idle cycles (IDLE, LOAD) separate the last stop bit from the next start bit.
REQ-027 A write to an empty FIFO while in IDLE is seen the following cycle; a simultaneous write and read while full is handled by the FIFO, with the write dropped.

Reset
REQ-028 Reset values: sOut=1, busy=0, txDone=0, FSM=IDLE, counters=0, FIFO empty (fifoEmpty=1, fifoFull=0).
REQ-029 Reset mid-frame aborts the frame immediately: sOut goes to 1 asynchronously, and queued data is discarded.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: the parityEn and parityOdd ports and the PARITY state exist.
REQ-031 Macro UART_TX_PARITY_EN undefined: those ports and the PARITY state are absent, and DATA goes directly to STOP.

Structure
REQ-032 Package uart_pkg holds the FSM state typedef and the LSB-first bit-order and idle-level constants, shared with the receiver.
REQ-033 The FIFO is an instance of the existing fifo module, with read data valid one cycle after rd_en; no other sub-module is used.

Verification
REQ-034 Reset, then baudDiv=3, stop2=0, no parity, write 0x55 -> sOut 0,1,0,1,0,1,0,1,0 then stop 1, each level held 4 clocks; txDone pulses once, 40 clocks after the start bit begins.
REQ-035 Parity build, parityEn=1, parityOdd=0, write 0x07 -> parity bit 1; with parityOdd=1 -> parity bit 0.
REQ-036 stop2=1, baudDiv=1, write 0xA3 -> sOut high for 4 clocks after the last data bit before txDone; busy falls with txDone.
REQ-037 Write 33 words with no drain at FDEPTH=32 -> fifoFull rises after the 32nd write, the 33rd is dropped, and exactly 32 frames are sent.
REQ-038 Two words written back-to-back -> second start bit begins exactly 2 clocks after the first frame's stop period ends.
REQ-039 rst asserted during DATA -> sOut=1 and busy=0 without waiting for a clock edge; after release, no further frames are sent.
